// File: rtl/breakout_ball_ctrl.sv
// Ball motion controller for the 800x600 breakout playfield.
// Owns the ball position, folds block/wall/paddle contacts into a new
// direction once per frame, and sequences serve / play / miss / game over
// together with the lives counter.
module breakout_ball_ctrl #(
  parameter int BALL_SIZE   = 8,
  parameter int SPEED       = 2,
  parameter int H_MAX       = 799,
  parameter int V_MAX       = 599,
  parameter int START_X     = 396,
  parameter int START_Y     = 540,
  parameter int PADDLE_Y_T  = 580,
  parameter int LIVES       = 3,
  parameter int MISS_FRAMES = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        refr_tick,
  input  logic        launch,
  input  logic        hit_u,
  input  logic        hit_d,
  input  logic        hit_l,
  input  logic        hit_r,
  input  logic [10:0] paddle_x_l,
  input  logic [10:0] paddle_x_r,
  input  logic [10:0] pix_x,
  input  logic [10:0] pix_y,
  output logic [10:0] ball_x_l,
  output logic [10:0] ball_x_r,
  output logic [10:0] ball_y_t,
  output logic [10:0] ball_y_b,
  output logic        ball_on,
  output logic [1:0]  lives,
  output logic        game_over
);

  localparam logic [10:0] SPEED_C   = 11'(SPEED);
  localparam logic [10:0] SIZE_M1   = 11'(BALL_SIZE - 1);
  localparam logic [10:0] X_TURN    = 11'(H_MAX - SPEED);
  localparam logic [10:0] Y_MISS    = 11'(V_MAX - SPEED);
  localparam logic [10:0] PAD_TOP   = 11'(PADDLE_Y_T);
  localparam logic [10:0] PAD_BOT   = 11'(PADDLE_Y_T + 3);
  localparam logic [10:0] START_X_C = 11'(START_X);
  localparam logic [10:0] START_Y_C = 11'(START_Y);
  localparam logic signed [11:0] STEP_S  = 12'(SPEED);
  localparam logic signed [11:0] X_LIM_S = 12'(H_MAX - BALL_SIZE + 1);
  localparam logic signed [11:0] Y_LIM_S = 12'(V_MAX - BALL_SIZE + 1);
  localparam int CNT_W = $clog2(MISS_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MISS_FRAMES - 1);
  localparam logic [1:0] LIVES_C = 2'(LIVES);

  typedef enum logic [1:0] {SERVE, PLAY, MISS, OVER} state_t;

  state_t            state_reg, state_next;
  logic [10:0]       x_l_reg, x_l_next;
  logic [10:0]       y_t_reg, y_t_next;
  logic              dir_x_reg, dir_x_next;   // 1 = moving right (+1)
  logic              dir_y_reg, dir_y_next;   // 1 = moving down (+1)
  logic [1:0]        lives_reg, lives_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [3:0]        latch_reg, latch_next;   // {u, d, l, r}

  logic [3:0]        hit_vec;
  logic [3:0]        hit_eff;
  logic              new_dx, new_dy;
  logic              move_dx, move_dy;
  logic              paddle_contact;
  logic              miss_now;
  logic signed [11:0] x_sum, y_sum;
  logic [10:0]       x_moved, y_moved;

  assign hit_vec = {hit_u, hit_d, hit_l, hit_r};

  // A pulse arriving on the tick cycle is consumed by that tick; latches only live in PLAY.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_latch
      assign hit_eff[gi]    = latch_reg[gi] | hit_vec[gi];
      assign latch_next[gi] = (state_reg == PLAY) && !refr_tick && hit_eff[gi];
    end
  endgenerate

  assign ball_x_l  = x_l_reg;
  assign ball_x_r  = x_l_reg + SIZE_M1;
  assign ball_y_t  = y_t_reg;
  assign ball_y_b  = y_t_reg + SIZE_M1;
  assign lives     = lives_reg;
  assign game_over = (state_reg == OVER);
  assign ball_on   = (pix_x >= ball_x_l) && (pix_x <= ball_x_r) &&
                     (pix_y >= ball_y_t) && (pix_y <= ball_y_b) &&
                     (state_reg != OVER);

  assign paddle_contact = (ball_y_b >= PAD_TOP) && (ball_y_b <= PAD_BOT) &&
                          (ball_x_r >= paddle_x_l) && (ball_x_l <= paddle_x_r) &&
                          dir_y_reg;
  assign miss_now = (ball_y_b >= Y_MISS) && !paddle_contact;

  // Clamp a signed candidate coordinate into [0, lim].
  function automatic logic [10:0] clamp(input logic signed [11:0] v,
                                        input logic signed [11:0] lim);
    if (v < 12'sd0)
      return 11'd0;
    else if (v > lim)
      return lim[10:0];
    else
      return v[10:0];
  endfunction

  // Direction decision for a PLAY tick: block hits first, then walls, then paddle.
  always_comb begin
    new_dx = dir_x_reg;
    if (hit_eff[1] && hit_eff[0])  new_dx = ~dir_x_reg;
    else if (hit_eff[1])           new_dx = 1'b0;
    else if (hit_eff[0])           new_dx = 1'b1;
    else if (x_l_reg <= SPEED_C)   new_dx = 1'b1;
    else if (ball_x_r >= X_TURN)   new_dx = 1'b0;

    new_dy = dir_y_reg;
    if (hit_eff[3] && hit_eff[2])  new_dy = ~dir_y_reg;
    else if (hit_eff[3])           new_dy = 1'b0;
    else if (hit_eff[2])           new_dy = 1'b1;
    else if (y_t_reg <= SPEED_C)   new_dy = 1'b1;
    else if (paddle_contact)       new_dy = 1'b0;
  end

  // Candidate position one step along the chosen direction (serve launches right/up).
  always_comb begin
    move_dx = (state_reg == PLAY) ? new_dx : 1'b1;
    move_dy = (state_reg == PLAY) ? new_dy : 1'b0;
    x_sum   = $signed({1'b0, x_l_reg}) + (move_dx ? STEP_S : -STEP_S);
    y_sum   = $signed({1'b0, y_t_reg}) + (move_dy ? STEP_S : -STEP_S);
    x_moved = clamp(x_sum, X_LIM_S);
    y_moved = clamp(y_sum, Y_LIM_S);
  end

  // Game sequencing and per-frame ball update.
  always_comb begin
    state_next = state_reg;
    x_l_next   = x_l_reg;
    y_t_next   = y_t_reg;
    dir_x_next = dir_x_reg;
    dir_y_next = dir_y_reg;
    lives_next = lives_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      SERVE: begin
        if (refr_tick && launch) begin
          state_next = PLAY;
          dir_x_next = 1'b1;
          dir_y_next = 1'b0;
          x_l_next   = x_moved;
          y_t_next   = y_moved;
        end
      end
      PLAY: begin
        if (refr_tick) begin
          dir_x_next = new_dx;
          dir_y_next = new_dy;
          if (miss_now) begin
            state_next = MISS;
            cnt_next   = '0;
          end else begin
            x_l_next = x_moved;
            y_t_next = y_moved;
          end
        end
      end
      MISS: begin
        if (refr_tick) begin
          if (cnt_reg == CNT_LAST) begin
            cnt_next   = '0;
            lives_next = lives_reg - 2'd1;
            if (lives_reg == 2'd1) begin
              state_next = OVER;
            end else begin
              state_next = SERVE;
              x_l_next   = START_X_C;
              y_t_next   = START_Y_C;
              dir_x_next = 1'b1;
              dir_y_next = 1'b0;
            end
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      default: ;  // OVER holds until reset
    endcase
  end

  // State register; reset parks the ball for a fresh game.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= SERVE;
      x_l_reg   <= START_X_C;
      y_t_reg   <= START_Y_C;
      dir_x_reg <= 1'b1;
      dir_y_reg <= 1'b0;
      lives_reg <= LIVES_C;
      cnt_reg   <= '0;
      latch_reg <= '0;
    end else begin
      state_reg <= state_next;
      x_l_reg   <= x_l_next;
      y_t_reg   <= y_t_next;
      dir_x_reg <= dir_x_next;
      dir_y_reg <= dir_y_next;
      lives_reg <= lives_next;
      cnt_reg   <= cnt_next;
      latch_reg <= latch_next;
    end
  end

endmodule
